// File: rtl/bf16_pkg.sv
// Shared bfloat16 field layout, accumulator FSM states and small helpers.
// Used by bf16_accum and addsub.
package bf16_pkg;

  localparam int unsigned BF16_W   = 16;
  localparam int unsigned SIGN_BIT = 15;
  localparam int unsigned EXP_MSB  = 14;
  localparam int unsigned EXP_LSB  = 7;
  localparam int unsigned MAN_MSB  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

  function automatic logic [BF16_W-1:0] bf16_neg(input logic [BF16_W-1:0] x);
    return {~x[SIGN_BIT], x[EXP_MSB:0]};
  endfunction

  function automatic logic bf16_is_zero(input logic [BF16_W-1:0] x);
    return (x[EXP_MSB:EXP_LSB] == '0);
  endfunction

endpackage

// File: rtl/addsub.sv
// Combinational bfloat16 add/sub: result = a + (operation ? -b : b).
// Round-to-nearest-even; subnormal inputs and results flush to signed zero.
module addsub
  import bf16_pkg::*;
(
  input  logic [BF16_W-1:0] a,
  input  logic [BF16_W-1:0] b,
  input  logic              operation,
  output logic [BF16_W-1:0] result
);

  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [7:0]  siga, sigb;
  logic [14:0] maga, magb;
  logic        a_nan, b_nan, a_inf, b_inf;

  assign sa    = a[SIGN_BIT];
  assign sb    = b[SIGN_BIT] ^ operation;
  assign ea    = a[EXP_MSB:EXP_LSB];
  assign eb    = b[EXP_MSB:EXP_LSB];
  assign siga  = (ea == 8'd0) ? 8'd0 : {1'b1, a[MAN_MSB:0]};
  assign sigb  = (eb == 8'd0) ? 8'd0 : {1'b1, b[MAN_MSB:0]};
  assign maga  = (ea == 8'd0) ? 15'd0 : a[EXP_MSB:0];
  assign magb  = (eb == 8'd0) ? 15'd0 : b[EXP_MSB:0];
  assign a_nan = (ea == 8'hff) && (a[MAN_MSB:0] != 7'd0);
  assign b_nan = (eb == 8'hff) && (b[MAN_MSB:0] != 7'd0);
  assign a_inf = (ea == 8'hff) && (a[MAN_MSB:0] == 7'd0);
  assign b_inf = (eb == 8'hff) && (b[MAN_MSB:0] == 7'd0);

  logic        swap, sl, ss, found, rnd;
  logic [7:0]  el, es, sigl, sigs, d;
  logic [17:0] tmp;
  logic [10:0] al, big, n;
  logic [11:0] s;
  logic [3:0]  lz;
  logic [9:0]  e;
  logic [8:0]  mr;

  always_comb begin
    swap = (magb > maga);
    sl   = swap ? sb : sa;
    ss   = swap ? sa : sb;
    el   = swap ? eb : ea;
    es   = swap ? ea : eb;
    sigl = swap ? sigb : siga;
    sigs = swap ? siga : sigb;
    d    = el - es;

    // Align the smaller operand, keeping guard, round and a sticky bit.
    tmp = {sigs, 10'd0} >> d;
    if (d >= 8'd10) begin
      al = {10'd0, |sigs};
    end else begin
      al = {tmp[17:8], |tmp[7:0]};
    end
    big = {sigl, 3'b000};
    s   = (sl == ss) ? ({1'b0, big} + {1'b0, al}) : ({1'b0, big} - {1'b0, al});

    lz    = 4'd0;
    found = 1'b0;
    for (int i = 10; i >= 0; i--) begin
      if (!found) begin
        if (s[i]) found = 1'b1;
        else      lz = lz + 4'd1;
      end
    end

    if (s[11]) begin
      n = {s[11:2], s[1] | s[0]};
      e = {2'b00, el} + 10'd1;
    end else begin
      n = s[10:0] << lz;
      e = {2'b00, el} - {6'd0, lz};
    end

    rnd = n[2] & (n[1] | n[0] | n[3]);
    mr  = {1'b0, n[10:3]} + {8'd0, rnd};
    if (mr[8]) e = e + 10'd1;

    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      result = 16'h7fc0;
    end else if (a_inf) begin
      result = {sa, 8'hff, 7'd0};
    end else if (b_inf) begin
      result = {sb, 8'hff, 7'd0};
    end else if (s == 12'd0) begin
      result = {sl & ss, 15'd0};
    end else if (!s[11] && ({4'd0, lz} >= el)) begin
      result = {sl, 15'd0};
    end else if (e >= 10'd255) begin
      result = {sl, 8'hff, 7'd0};
    end else begin
      result = {sl, e[7:0], mr[6:0]};
    end
  end

endmodule

// File: rtl/bf16_accum.sv
// Streaming bf16 packet accumulator in front of addsub, valid/ready on both sides.
// Optional BF16_ACC_ZERO_BYPASS_EN: operands with exponent 0 are treated as signed zero.
module bf16_accum
  import bf16_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BF16_W-1:0] in_data,
  input  logic              in_sub,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BF16_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count
);

  acc_state_t        state_q, state_d;
  logic [BF16_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BF16_W-1:0] operand, sum;
  logic              accept;

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_data  = acc_q;
  assign out_count = cnt_q;
  assign accept    = in_valid && in_ready;
  assign operand   = in_sub ? bf16_neg(in_data) : in_data;

  addsub u_addsub (
    .a        (acc_q),
    .b        (in_data),
    .operation(in_sub),
    .result   (sum)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = operand;
          cnt_d   = CNT_W'(1);
          state_d = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
`ifdef BF16_ACC_ZERO_BYPASS_EN
          if (bf16_is_zero(in_data)) begin
            acc_d = acc_q;
          end else if (bf16_is_zero(acc_q)) begin
            acc_d = operand;
          end else begin
            acc_d = sum;
          end
`else
          acc_d = sum;
`endif
          cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          if (in_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bf16_accum.sv
// Directed self-checking bench for bf16_accum (default CNT_W and a CNT_W=2 copy).
module tb_bf16_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        in_sub = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [15:0] out_data;
  logic [7:0]  out_count;
  logic        in_ready2, out_valid2;
  logic [15:0] out_data2;
  logic [1:0]  out_count2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bf16_accum dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sub   (in_sub),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_count(out_count)
  );

  bf16_accum #(.CNT_W(2)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready2),
    .in_data  (in_data),
    .in_sub   (in_sub),
    .in_last  (in_last),
    .out_valid(out_valid2),
    .out_ready(out_ready),
    .out_data (out_data2),
    .out_count(out_count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] d, input logic s, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = s;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_sub   = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    tests++; if (out_data !== 16'h0000) begin fails++; $display("FAIL reset out_data: got %h want 0000", out_data); end
    tests++; if (out_count !== 8'd0) begin fails++; $display("FAIL reset out_count: got %0d want 0", out_count); end
  endtask

  task automatic test_single_neg();
    beat(16'h3f80, 1'b1, 1'b1);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single out_valid: got %b want 1", out_valid); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL single in_ready: got %b want 0", in_ready); end
    tests++; if (out_data !== 16'hbf80) begin fails++; $display("FAIL single out_data: got %h want bf80", out_data); end
    tests++; if (out_count !== 8'd1) begin fails++; $display("FAIL single out_count: got %0d want 1", out_count); end
    drain();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single drain out_valid: got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL single drain in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_two_beat_add();
    beat(16'h3f80, 1'b0, 1'b0);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL add mid out_valid: got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL add mid in_ready: got %b want 1", in_ready); end
    beat(16'h4000, 1'b0, 1'b1);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL add out_valid: got %b want 1", out_valid); end
    tests++; if (out_data !== 16'h4040) begin fails++; $display("FAIL add out_data: got %h want 4040", out_data); end
    tests++; if (out_count !== 8'd2) begin fails++; $display("FAIL add out_count: got %0d want 2", out_count); end
    drain();
  endtask

  task automatic test_subtract();
    beat(16'h4040, 1'b0, 1'b0);
    beat(16'h3f80, 1'b1, 1'b1);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL sub out_valid: got %b want 1", out_valid); end
    tests++; if (out_data !== 16'h4000) begin fails++; $display("FAIL sub out_data: got %h want 4000", out_data); end
    tests++; if (out_count !== 8'd2) begin fails++; $display("FAIL sub out_count: got %0d want 2", out_count); end
    drain();
  endtask

  task automatic test_backpressure();
    beat(16'h4000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      // Offer a beat while holding; it must be ignored.
      in_valid = 1'b1;
      in_data  = 16'h3f80;
      in_last  = 1'b1;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp[%0d] out_valid: got %b want 1", i, out_valid); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp[%0d] in_ready: got %b want 0", i, in_ready); end
      tests++; if (out_data !== 16'h4000) begin fails++; $display("FAIL bp[%0d] out_data: got %h want 4000", i, out_data); end
      tests++; if (out_count !== 8'd1) begin fails++; $display("FAIL bp[%0d] out_count: got %0d want 1", i, out_count); end
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    drain();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp release out_valid: got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp release in_ready: got %b want 1", in_ready); end
    tests++; if (out_data !== 16'h4000) begin fails++; $display("FAIL bp release out_data: got %h want 4000", out_data); end
  endtask

  task automatic test_reset_mid_packet();
    beat(16'h3f80, 1'b0, 1'b0);
    beat(16'h4000, 1'b0, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h4040;
    in_last  = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid out_valid: got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstmid in_ready: got %b want 1", in_ready); end
    tests++; if (out_count !== 8'd0) begin fails++; $display("FAIL rstmid out_count: got %0d want 0", out_count); end
    beat(16'h3f00, 1'b0, 1'b1);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rstmid pkt out_valid: got %b want 1", out_valid); end
    tests++; if (out_data !== 16'h3f00) begin fails++; $display("FAIL rstmid pkt out_data: got %h want 3f00", out_data); end
    tests++; if (out_count !== 8'd1) begin fails++; $display("FAIL rstmid pkt out_count: got %0d want 1", out_count); end
    drain();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      beat(16'h3f80, 1'b0, (i == 4));
    end
    tests++; if (out_valid2 !== 1'b1) begin fails++; $display("FAIL sat out_valid2: got %b want 1", out_valid2); end
    tests++; if (out_count2 !== 2'd3) begin fails++; $display("FAIL sat out_count2: got %0d want 3", out_count2); end
    tests++; if (out_count !== 8'd5) begin fails++; $display("FAIL sat out_count: got %0d want 5", out_count); end
    tests++; if (out_data !== 16'h40a0) begin fails++; $display("FAIL sat out_data: got %h want 40a0", out_data); end
    tests++; if (out_data2 !== 16'h40a0) begin fails++; $display("FAIL sat out_data2: got %h want 40a0", out_data2); end
    drain();
  endtask

  task automatic test_zero_operand();
    beat(16'h0000, 1'b0, 1'b0);
    beat(16'h3fc0, 1'b0, 1'b1);
    tests++; if (out_data !== 16'h3fc0) begin fails++; $display("FAIL zero out_data: got %h want 3fc0", out_data); end
    tests++; if (out_count !== 8'd2) begin fails++; $display("FAIL zero out_count: got %0d want 2", out_count); end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_neg();
    test_two_beat_add();
    test_subtract();
    test_backpressure();
    test_reset_mid_packet();
    test_saturation();
    test_zero_operand();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bf16_accum.md
# bf16_accum

Streaming bfloat16 accumulator that sits directly upstream of the combinational bfloat16 add/sub unit (`addsub`). It accepts a packet of bf16 operands over a valid/ready input and drives the running sum and each new operand into `addsub`. It registers the result every accepted beat and presents the final packet sum over a valid/ready output. This is the first sequential stage around the add/sub datapath and the building block for dot-product and reduction paths.

## Interface
- `CNT_W`, default 8: width of the beat counter; the counter saturates at 2^CNT_W−1.
- `clk` input 1: the only clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: the input beat is valid.
- `in_ready` output 1: the block can accept a beat; equals `state != HOLD`.
- `in_data` input 16: bf16 operand.
- `in_sub` input 1: 1 means the operand is subtracted from the running sum.
- `in_last` input 1: the beat is the final beat of the packet.
- `out_valid` output 1: the packet result is valid.
- `out_ready` input 1: downstream accepts the result.
- `out_data` output 16: bf16 packet sum, from the accumulator register.
- `out_count` output CNT_W: number of beats in the packet, saturating.

## Operation
- **FSM states**
  - IDLE: no packet open.
  - ACCUM: packet open, at least one beat absorbed.
  - HOLD: result presented on the output.
- **Accept:** a beat is accepted when `in_valid && in_ready`.
- **First beat**, accepted in IDLE:
  - `acc <= in_sub ? {~in_data[15], in_data[14:0]} : in_data`.
  - `cnt <= 1`.
  - Next state is ACCUM, or HOLD if `in_last` is also set.
- **Later beats**, accepted in ACCUM:
  - `acc <= addsub(a=acc, b=in_data, operation=in_sub)`.
  - `cnt <= sat(cnt+1)`.
  - Next state is HOLD if `in_last` is set.
- **Hold:** in HOLD, `out_valid` = 1. `acc` and `cnt` are frozen. `out_data` and `out_count` stay stable until `out_valid && out_ready`, after which the next state is IDLE.
- **No input in HOLD:** `in_ready` = 0 in HOLD, so a new beat can never arrive in the same cycle as the output handshake.
- **Arithmetic:** the sum uses `addsub` exactly as that unit computes it, with no extra rounding. Without the zero-bypass feature, zero and special encodings pass to the adder unmodified.
- **Reset:** on `rst`, state = IDLE, `acc` = 16'h0000, `cnt` = 0, `out_valid` = 0. `in_ready` is 1 from the first cycle after reset. Beats presented in a cycle where `rst` is high are discarded. Reset in the middle of a packet drops the partial sum.

## Timing
- Every accepted beat updates `acc` at the next edge, giving a throughput of 1 beat per cycle within a packet.
- `out_valid` rises on the edge after the `in_last` beat is accepted, a latency of 1 cycle.
- After the output handshake, the block returns to IDLE and `in_ready` rises the next cycle. There is one bubble per packet.
- Critical path: `acc` register → `addsub` → `acc` register. No pipelining is inside the adder.

## Configuration
- **`BF16_ACC_ZERO_BYPASS_EN` defined:** any operand with exponent field 0 is treated as signed zero.
  - An incoming zero in ACCUM leaves `acc` unchanged; `cnt` still increments.
  - If `acc` has exponent 0 in ACCUM, `acc` is loaded with the sign-adjusted `in_data` and the adder result is ignored.
- **Not defined:** every later beat goes through `addsub` unconditionally.

## Structure
- **Package `bf16_pkg`** holds:
  - `BF16_W` = 16.
  - Field localparams: `SIGN_BIT` = 15, `EXP_MSB` = 14, `EXP_LSB` = 7, `MAN_MSB` = 6.
  - The `acc_state_t` enum: IDLE, ACCUM, HOLD.
  - Function `bf16_neg` (sign flip).
  - Function `bf16_is_zero` (exponent == 0).
- **Sub-modules:** one instance of the existing `addsub` as the combinational datapath. The FSM, counter and bypass mux live in `bf16_accum`; no other sub-module is needed.

## Test plan
- **Single-beat packet with negation:** one beat 16'h3F80 with `in_sub`=1 and `in_last`=1 → next cycle `out_valid`=1, `out_data`=16'hBF80, `out_count`=1.
- **Two-beat add:** 16'h3F80 then 16'h4000 (last) in back-to-back cycles → `out_data`=16'h4040 (3.0), `out_count`=2, with `out_valid` one cycle after the second beat.
- **Subtraction:** 16'h4040 then 16'h3F80 with `in_sub`=1 (last) → `out_data`=16'h4000 (2.0).
- **Backpressure:** hold `out_ready`=0 for 5 cycles in HOLD → `out_data`/`out_count` stay stable and `in_ready`=0 throughout. Then assert `out_ready` for 1 cycle → `out_valid`=0 and `in_ready`=1 on the following cycle.
- **Reset mid-packet:** accept 16'h3F80 and 16'h4000, pulse `rst` for 1 cycle, then send 16'h3F00 (last) → `out_data`=16'h3F00, `out_count`=1.
- **Saturation and bypass:**
  - With CNT_W=2, a 5-beat packet of 16'h3F80 → `out_count`=3.
  - With `BF16_ACC_ZERO_BYPASS_EN`, 16'h0000 then 16'h3FC0 (last) → `out_data`=16'h3FC0.
